vga_sync_gen: RTL and testbench

- 640x480@60 Hz VGA timing generator that sits directly upstream of every pattern generator.
- Produces the shared pattern interface signals: pixel coordinates x/y, active-video flag, and active-low hsync/vsync.
- Also produces the paced next_frame animation strobe, with selectable divide-by-frame speed, pause, and single-step.
- clk is the pixel clock (25.175 MHz nominal); one pixel per cycle.

---
 rtl/vga_sync_gen.sv | 131 +++++++++++++
 tb/tb_vga_sync_gen.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel/line counters, registered syncs, vblank tick and
// a paced animation strobe with divide-by-frame, pause and single-step.
module vga_sync_gen #(
   parameter int H_VISIBLE = 640,
   parameter int H_FRONT   = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BACK    = 48,
   parameter int V_VISIBLE = 480,
   parameter int V_FRONT   = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BACK    = 33
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ena,
   input  logic [1:0] speed,
   input  logic       pause,
   input  logic       step,
   output logic [9:0] x,
   output logic [9:0] y,
   output logic       active,
   output logic       hsync,
   output logic       vsync,
   output logic       frame_tick,
   output logic       next_frame
);

   localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
   localparam int HS_START = H_VISIBLE + H_FRONT;
   localparam int HS_END   = HS_START + H_SYNC;
   localparam int VS_START = V_VISIBLE + V_FRONT;
   localparam int VS_END   = VS_START + V_SYNC;

   logic [9:0] x_reg, x_next;
   logic [9:0] y_reg, y_next;
   logic       hsync_reg, hsync_next;
   logic       vsync_reg, vsync_next;
   logic       frame_tick_reg, frame_tick_next;
   logic       next_frame_reg, next_frame_next;
   logic [2:0] frame_div_reg, frame_div_next;
   logic       step_pending_reg, step_pending_next;
   logic       step_q_reg;
   logic [2:0] mask;
   logic       step_rise;

   // Counter advance; syncs and the tick are derived from the next position so
   // that, once registered, they line up with x/y in the same cycle.
   always_comb begin
      x_next = x_reg + 10'd1;
      y_next = y_reg;
      if (x_reg == 10'(H_TOTAL - 1)) begin
         x_next = '0;
         if (y_reg == 10'(V_TOTAL - 1)) y_next = '0;
         else                           y_next = y_reg + 10'd1;
      end
      hsync_next      = !((x_next >= 10'(HS_START)) && (x_next < 10'(HS_END)));
      vsync_next      = !((y_next >= 10'(VS_START)) && (y_next < 10'(VS_END)));
      frame_tick_next = (x_next == '0) && (y_next == 10'(V_VISIBLE));
   end

   always_comb begin
      case (speed)
         2'd0:    mask = 3'd0;
         2'd1:    mask = 3'd1;
         2'd2:    mask = 3'd3;
         default: mask = 3'd7;
      endcase
   end

   assign step_rise = step && !step_q_reg;

   // Pacing decision uses the pre-increment divider; a paused tick only
   // consumes a pending step and leaves the divider alone.
   always_comb begin
      next_frame_next   = 1'b0;
      frame_div_next    = frame_div_reg;
      step_pending_next = step_pending_reg;
      if (frame_tick_next) begin
         if (!pause) begin
            next_frame_next = ((frame_div_reg & mask) == 3'd0);
            frame_div_next  = frame_div_reg + 3'd1;
         end else begin
            next_frame_next = step_pending_reg;
         end
      end
      if (!pause)
         step_pending_next = 1'b0;
      else if (frame_tick_next && step_pending_reg)
         step_pending_next = 1'b0;
      else if (step_rise)
         step_pending_next = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x_reg            <= '0;
         y_reg            <= '0;
         hsync_reg        <= 1'b1;
         vsync_reg        <= 1'b1;
         frame_tick_reg   <= 1'b0;
         next_frame_reg   <= 1'b0;
         frame_div_reg    <= '0;
         step_pending_reg <= 1'b0;
         step_q_reg       <= 1'b0;
      end else if (ena) begin
         x_reg            <= x_next;
         y_reg            <= y_next;
         hsync_reg        <= hsync_next;
         vsync_reg        <= vsync_next;
         frame_tick_reg   <= frame_tick_next;
         next_frame_reg   <= next_frame_next;
         frame_div_reg    <= frame_div_next;
         step_pending_reg <= step_pending_next;
         step_q_reg       <= step;
      end else begin
         // Stalled: everything holds, but pulses must not stretch.
         frame_tick_reg <= 1'b0;
         next_frame_reg <= 1'b0;
      end
   end

   assign x          = x_reg;
   assign y          = y_reg;
   assign active     = (x_reg < 10'(H_VISIBLE)) && (y_reg < 10'(V_VISIBLE));
   assign hsync      = hsync_reg;
   assign vsync      = vsync_reg;
   assign frame_tick = frame_tick_reg;
   assign next_frame = next_frame_reg;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen using a shrunken timing (24x14 total) so many frames
// fit in a short run; a cycle-count model is compared against the DUT each cycle.
module tb_vga_sync_gen;

   localparam int HV = 16, HF = 2, HS = 3, HB = 3;
   localparam int VV = 8,  VF = 2, VS = 2, VB = 2;
   localparam int HT = HV + HF + HS + HB;   // 24
   localparam int VT = VV + VF + VS + VB;   // 14
   localparam int FT = HT * VT;             // 336

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       ena = 1'b1;
   logic [1:0] speed = 2'd0;
   logic       pause = 1'b0;
   logic       step = 1'b0;
   logic [9:0] x, y;
   logic       active, hsync, vsync, frame_tick, next_frame;

   vga_sync_gen #(
      .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
      .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
   ) dut (
      .clk(clk), .rst(rst), .ena(ena), .speed(speed), .pause(pause), .step(step),
      .x(x), .y(y), .active(active), .hsync(hsync), .vsync(vsync),
      .frame_tick(frame_tick), .next_frame(next_frame)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model: position is the enabled-cycle count modulo the frame; pacing is
   // expressed as "fire when the count of unpaused ticks is a multiple of the period".
   int m_t = 0;
   int m_uticks = 0;
   bit m_step_q = 0, m_pend = 0, e_tick = 0, e_nf = 0;

   always @(posedge clk) begin
      int t_new;
      int ex, ey;
      bit rise;
      if (rst) begin
         m_t = 0; m_uticks = 0; m_step_q = 0; m_pend = 0; e_tick = 0; e_nf = 0;
      end else if (ena) begin
         t_new  = (m_t + 1) % FT;
         rise   = step && !m_step_q;
         e_tick = (t_new == VV * HT);
         e_nf   = 0;
         if (e_tick) begin
            if (!pause) begin
               e_nf = ((m_uticks % (1 << speed)) == 0);
               m_uticks++;
            end else begin
               e_nf = m_pend;
            end
         end
         if (!pause)               m_pend = 0;
         else if (e_tick && m_pend) m_pend = 0;
         else if (rise)            m_pend = 1;
         m_step_q = step;
         m_t = t_new;
      end else begin
         e_tick = 0; e_nf = 0;
      end
      #1;
      ex = m_t % HT;
      ey = m_t / HT;
      chk("x", int'(x), ex);
      chk("y", int'(y), ey);
      chk("active", int'(active), int'(ex < HV && ey < VV));
      chk("hsync", int'(hsync), int'(!(ex >= HV + HF && ex < HV + HF + HS)));
      chk("vsync", int'(vsync), int'(!(ey >= VV + VF && ey < VV + VF + VS)));
      chk("frame_tick", int'(frame_tick), int'(e_tick));
      chk("next_frame", int'(next_frame), int'(e_nf));
   end

   // Event counters sampled mid-cycle, cleared by the stimulus on negedges.
   int cyc = 0, tick_cnt = 0, nf_cnt = 0, hs_low = 0, vs_low = 0;
   int last_tick_cyc = 0, last_nf_cyc = 0, nf_gap = 0;
   int hs_fall_x = -1, hs_rise_x = -1;
   logic prev_hs = 1'b1;

   always @(posedge clk) begin
      #2;
      cyc++;
      if (frame_tick) begin tick_cnt++; last_tick_cyc = cyc; end
      if (next_frame) begin nf_cnt++; nf_gap = cyc - last_nf_cyc; last_nf_cyc = cyc; end
      if (!hsync) hs_low++;
      if (!vsync) vs_low++;
      if (prev_hs && !hsync) hs_fall_x = int'(x);
      if (!prev_hs && hsync) hs_rise_x = int'(x);
      prev_hs = hsync;
   end

   task automatic wait_tick();
      int n;
      for (n = 0; n < 400; n++) begin
         @(negedge clk);
         if (frame_tick) break;
      end
      chk("tick_seen", int'(frame_tick), 1);
   endtask

   initial begin
      int c0;
      int n;

      // Reset state, checked while reset is held.
      #2 rst = 1'b1;
      #1;
      chk("rst_x", int'(x), 0);
      chk("rst_y", int'(y), 0);
      chk("rst_hsync", int'(hsync), 1);
      chk("rst_vsync", int'(vsync), 1);
      chk("rst_active", int'(active), 1);
      chk("rst_tick", int'(frame_tick), 0);
      chk("rst_nf", int'(next_frame), 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      repeat (HV) @(negedge clk);
      chk("x_after_visible", int'(x), 16);
      chk("active_after_visible", int'(active), 0);
      repeat (HT - HV) @(negedge clk);
      chk("x_line_wrap", int'(x), 0);
      chk("y_line_wrap", int'(y), 1);

      // One full line of hsync.
      hs_low = 0;
      repeat (HT) @(negedge clk);
      chk("hsync_low_cycles", hs_low, 3);
      chk("hsync_fall_x", hs_fall_x, 18);
      chk("hsync_rise_x", hs_rise_x, 21);

      // Two frames of vsync and ticks.
      vs_low = 0; tick_cnt = 0;
      repeat (2 * FT) @(negedge clk);
      chk("vsync_low_cycles", vs_low, 96);
      chk("ticks_in_two_frames", tick_cnt, 2);

      // speed=0: every frame.
      nf_cnt = 0;
      repeat (3) wait_tick();
      chk("speed0_pulses", nf_cnt, 3);
      chk("speed0_nf_on_tick", int'(next_frame), 1);
      wait_tick();
      chk("frame_period", cyc - last_tick_cyc + FT, FT);
      repeat (100) @(negedge clk);

      // speed=2 changed mid-frame: 2 pulses in 8 frames, 4 frames apart.
      speed = 2'd2;
      nf_cnt = 0;
      repeat (8) wait_tick();
      chk("speed2_pulses", nf_cnt, 2);
      chk("speed2_gap", nf_gap, 4 * FT);

      // speed=1 changed mid-frame: 2 pulses in 4 frames.
      repeat (50) @(negedge clk);
      speed = 2'd1;
      nf_cnt = 0;
      repeat (4) wait_tick();
      chk("speed1_pulses", nf_cnt, 2);

      // Paused: no pulses over 3 frames.
      repeat (30) @(negedge clk);
      speed = 2'd0;
      pause = 1'b1;
      nf_cnt = 0;
      repeat (3) wait_tick();
      chk("paused_pulses", nf_cnt, 0);

      // Two step edges in one frame yield exactly one pulse.
      nf_cnt = 0;
      step = 1'b1; repeat (2) @(negedge clk);
      step = 1'b0; repeat (2) @(negedge clk);
      step = 1'b1; repeat (2) @(negedge clk);
      step = 1'b0;
      wait_tick();
      chk("step_pulse_count", nf_cnt, 1);
      chk("step_pulse_on_tick", int'(next_frame), 1);

      // Step edge in a tick cycle lands in the following frame.
      wait_tick();
      chk("step_tick_no_nf", int'(next_frame), 0);
      step = 1'b1;
      nf_cnt = 0;
      repeat (3) @(negedge clk);
      step = 1'b0;
      wait_tick();
      chk("step_in_tick_deferred", nf_cnt, 1);
      pause = 1'b0;

      // Mid-frame reset.
      for (n = 0; n < 400; n++) begin
         @(negedge clk);
         if (x == 10'd20 && y == 10'd5) break;
      end
      chk("reached_20_5", int'(x == 10'd20 && y == 10'd5), 1);
      rst = 1'b1;
      #1;
      chk("midrst_x", int'(x), 0);
      chk("midrst_y", int'(y), 0);
      chk("midrst_hsync", int'(hsync), 1);
      chk("midrst_vsync", int'(vsync), 1);
      chk("midrst_nf", int'(next_frame), 0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      c0 = cyc;
      wait_tick();
      chk("first_tick_after_rst", last_tick_cyc - c0, VV * HT);
      chk("first_nf_after_rst", int'(next_frame), 1);

      // ena low for 50 cycles stretches the frame by 50.
      c0 = cyc;
      repeat (10) @(negedge clk);
      ena = 1'b0;
      repeat (50) @(negedge clk);
      chk("frozen_x", int'(x), 10);
      chk("frozen_y", int'(y), 8);
      ena = 1'b1;
      wait_tick();
      chk("stretched_period", last_tick_cyc - c0, FT + 50);

      repeat (5) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
